corr_scheduler: RTL and testbench

- Sequences one CORRELATOR instance through repeated integration frames: clear the accumulators, integrate for N timebase ticks, freeze, then snapshot the pulses payload.
- Serializes each snapshot as a framed byte stream (sync, frame count, payload, XOR checksum) over a valid/ready link toward the UART/transport.
- The snapshot buffer is double-buffered against the live accumulators, so the next integration overlaps transmission of the previous frame.

---
 rtl/corr_pkg.sv | 29 ++
 rtl/corr_frame_tx.sv | 109 ++++++++++
 rtl/corr_scheduler.sv | 158 +++++++++++++++
 tb/tb_corr_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator frame scheduler and its byte serializer.
package corr_pkg;

   // Integration sequencer states
   typedef enum logic [2:0] {
      INT_IDLE,
      INT_CLEAR,
      INT_INTEGRATE,
      INT_SETTLE,
      INT_SNAP
   } int_state_e;

   // Serializer states; each names the byte currently presented on tx_data
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_HDR0,
      TX_HDR1,
      TX_BODY,
      TX_CSUM
   } tx_state_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Bytes on the wire for one frame: sync, count, payload bytes, checksum
   function automatic int unsigned frame_bytes(input int unsigned payload_size);
      return payload_size / 8 + 3;
   endfunction

endpackage

// File: rtl/corr_frame_tx.sv
// Snapshot buffer plus valid/ready byte serializer for one correlator frame.
// The buffer is captured on load_i and then shifted out MSB byte first while
// the checksum is built from the bytes as they are placed on tx_data.
module corr_frame_tx
   import corr_pkg::*;
#(
   parameter int         PAYLOAD_SIZE = 96,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_i,
   input  logic [PAYLOAD_SIZE-1:0] payload_i,
   input  logic [7:0]              count_i,
   input  logic                    tx_ready_i,
   output logic [7:0]              tx_data_o,
   output logic                    tx_valid_o,
   output logic                    idle_o
);

   localparam int unsigned       NUM_BODY = frame_bytes(PAYLOAD_SIZE) - 3;
   localparam int                IDX_W    = $clog2(NUM_BODY + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BODY);

   tx_state_e               state_q;
   logic [PAYLOAD_SIZE-1:0] shadow_q;
   logic [7:0]              count_q;
   logic [7:0]              data_q;
   logic                    valid_q;
   logic [7:0]              csum_q;
   logic [IDX_W-1:0]        idx_q;

   logic                    xfer;
   logic                    launch;
   logic [7:0]              top_byte;

   assign xfer     = valid_q & tx_ready_i;
   assign top_byte = shadow_q[PAYLOAD_SIZE-1 -: 8];

   // The checksum handshake cycle counts as idle so a new snapshot can chain on directly
   assign idle_o = (state_q == TX_IDLE) || ((state_q == TX_CSUM) && xfer);
   assign launch = load_i && idle_o;

   assign tx_data_o  = data_q;
   assign tx_valid_o = valid_q;

   // Serializer: a launch captures the payload and presents sync; each accepted byte loads the next one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= TX_IDLE;
         shadow_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         csum_q   <= '0;
         idx_q    <= '0;
      end else if (launch) begin
         state_q  <= TX_HDR0;
         shadow_q <= payload_i;
         count_q  <= count_i;
         data_q   <= SYNC_BYTE;
         valid_q  <= 1'b1;
         csum_q   <= '0;
         idx_q    <= '0;
      end else begin
         unique case (state_q)
            TX_HDR0: begin
               if (xfer) begin
                  data_q  <= count_q;
                  state_q <= TX_HDR1;
               end
            end
            TX_HDR1: begin
               if (xfer) begin
                  data_q   <= top_byte;
                  csum_q   <= top_byte;
                  shadow_q <= shadow_q << 8;
                  idx_q    <= IDX_W'(1);
                  state_q  <= TX_BODY;
               end
            end
            TX_BODY: begin
               if (xfer) begin
                  if (idx_q == LAST_IDX) begin
                     data_q  <= csum_q;
                     state_q <= TX_CSUM;
                  end else begin
                     data_q   <= top_byte;
                     csum_q   <= csum_q ^ top_byte;
                     shadow_q <= shadow_q << 8;
                     idx_q    <= idx_q + IDX_W'(1);
                  end
               end
            end
            TX_CSUM: begin
               if (xfer) begin
                  valid_q <= 1'b0;
                  state_q <= TX_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/corr_scheduler.sv
// Sequences one correlator through clear / integrate / settle / snapshot frames and
// hands each snapshot to the framed byte serializer, which runs while the next frame integrates.
module corr_scheduler
   import corr_pkg::*;
#(
   parameter int         PAYLOAD_SIZE  = 96,
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    continuous,
   input  logic [31:0]             integration_ticks,
   input  logic                    tick,
   input  logic [PAYLOAD_SIZE-1:0] pulses,
   output logic                    corr_enable,
   output logic                    corr_clear,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic [7:0]              frame_count,
   output logic                    overrun
);

   if (((PAYLOAD_SIZE % 8) != 0) || (PAYLOAD_SIZE < 8)) begin : g_bad_payload
      $error("corr_scheduler: PAYLOAD_SIZE must be a nonzero multiple of 8");
   end

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("corr_scheduler: SETTLE_CYCLES must be at least 1");
   end

   localparam int               SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

   int_state_e       state_q;
   logic [31:0]      n_q;
   logic [31:0]      n_d;
   logic [31:0]      tick_cnt_q;
   logic [31:0]      tick_cnt_d;
   logic [SET_W-1:0] settle_cnt_q;
   logic             continuous_q;
   logic             corr_enable_q;
   logic             corr_clear_q;
   logic [7:0]       frame_count_q;
   logic             overrun_q;

   logic             tx_idle;
   logic             snap_load;

   // A zero frame length would never complete, so it is run as a single tick
   assign n_d        = (integration_ticks == 32'd0) ? 32'd1 : integration_ticks;
   assign tick_cnt_d = tick_cnt_q + 32'd1;
   assign snap_load  = (state_q == INT_SNAP) && tx_idle;

   assign corr_enable = corr_enable_q;
   assign corr_clear  = corr_clear_q;
   assign frame_count = frame_count_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != INT_IDLE) || tx_valid;

   // Integration sequencer with registered correlator controls, frame counter and overrun flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= INT_IDLE;
         n_q           <= '0;
         tick_cnt_q    <= '0;
         settle_cnt_q  <= '0;
         continuous_q  <= 1'b0;
         corr_enable_q <= 1'b0;
         corr_clear_q  <= 1'b0;
         frame_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         unique case (state_q)
            INT_IDLE: begin
               if (start && !stop) begin
                  state_q       <= INT_CLEAR;
                  continuous_q  <= continuous;
                  overrun_q     <= 1'b0;
                  corr_enable_q <= 1'b1;
                  corr_clear_q  <= 1'b1;
               end
            end
            INT_CLEAR: begin
               corr_clear_q <= 1'b0;
               if (stop) begin
                  state_q       <= INT_IDLE;
                  corr_enable_q <= 1'b0;
               end else begin
                  state_q    <= INT_INTEGRATE;
                  n_q        <= n_d;
                  tick_cnt_q <= '0;
               end
            end
            INT_INTEGRATE: begin
               if (stop) begin
                  state_q       <= INT_IDLE;
                  corr_enable_q <= 1'b0;
               end else if (tick) begin
                  tick_cnt_q <= tick_cnt_d;
                  if (tick_cnt_d == n_q) begin
                     state_q       <= INT_SETTLE;
                     corr_enable_q <= 1'b0;
                     settle_cnt_q  <= '0;
                  end
               end
            end
            INT_SETTLE: begin
               if (stop) begin
                  state_q <= INT_IDLE;
               end else if (settle_cnt_q == SET_LAST) begin
                  state_q <= INT_SNAP;
               end else begin
                  settle_cnt_q <= settle_cnt_q + SET_W'(1);
               end
            end
            INT_SNAP: begin
               frame_count_q <= frame_count_q + 8'd1;
               if (!tx_idle) begin
                  overrun_q <= 1'b1;
               end
               if (continuous_q && !stop) begin
                  state_q       <= INT_CLEAR;
                  corr_enable_q <= 1'b1;
                  corr_clear_q  <= 1'b1;
               end else begin
                  state_q <= INT_IDLE;
               end
            end
            default: begin
               state_q       <= INT_IDLE;
               corr_enable_q <= 1'b0;
               corr_clear_q  <= 1'b0;
            end
         endcase
      end
   end

   corr_frame_tx #(
      .PAYLOAD_SIZE (PAYLOAD_SIZE),
      .SYNC_BYTE    (SYNC_BYTE)
   ) u_frame_tx (
      .clk        (clk),
      .reset      (reset),
      .load_i     (snap_load),
      .payload_i  (pulses),
      .count_i    (frame_count_q),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .idle_o     (tx_idle)
   );

endmodule

// File: tb/tb_corr_scheduler.sv
// Directed-plus-random bench for corr_scheduler with a 16-bit payload.
// Expected frames come from a byte-level model of the wire format.
module tb_corr_scheduler;

   localparam int PW = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic          stop;
   logic          continuous;
   logic [31:0]   integration_ticks;
   logic          tick;
   logic [PW-1:0] pulses;
   logic          corr_enable;
   logic          corr_clear;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic [7:0]    frame_count;
   logic          overrun;

   int            checks;
   int            errors;
   int            readyMode;
   int            validCycles;
   logic [7:0]    rxq[$];
   logic [7:0]    expq[$];
   logic [7:0]    modelCount;
   logic          stallPending;
   logic [7:0]    stallData;

   corr_scheduler #(
      .PAYLOAD_SIZE  (PW),
      .SETTLE_CYCLES (2),
      .SYNC_BYTE     (8'hA5)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .stop              (stop),
      .continuous        (continuous),
      .integration_ticks (integration_ticks),
      .tick              (tick),
      .pulses            (pulses),
      .corr_enable       (corr_enable),
      .corr_clear        (corr_clear),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .busy              (busy),
      .frame_count       (frame_count),
      .overrun           (overrun)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sink readiness: 0 always ready, 1 toggling, 2 random, 3 stalled
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // Link monitor: collects transferred bytes and checks that stalled bytes hold
   always @(negedge clk) begin
      if (!reset) begin
         stallPending = 1'b0;
      end else begin
         if (stallPending) begin
            checks++;
            assert (tx_valid === 1'b1 && tx_data === stallData) else begin
               errors++;
               $error("FAIL stall_hold observed valid=%0b data=%0h expected valid=1 data=%0h",
                      tx_valid, tx_data, stallData);
            end
         end
         if (tx_valid === 1'b1) validCycles++;
         if (tx_valid === 1'b1 && tx_ready === 1'b1) rxq.push_back(tx_data);
         stallPending = (tx_valid === 1'b1) && (tx_ready === 1'b0);
         stallData    = tx_data;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic doStart, input logic doStop);
      @(posedge clk);
      #1;
      start = doStart;
      stop  = doStop;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic pulseTick();
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   // Reference frame: sync, count, payload bytes MSB first, XOR of payload bytes
   task automatic expectFrame(input logic [7:0] cnt, input logic [PW-1:0] p);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      expq.push_back(8'hA5);
      expq.push_back(cnt);
      for (int k = PW / 8 - 1; k >= 0; k--) begin
         b = 8'(p >> (k * 8));
         expq.push_back(b);
         x = x ^ b;
      end
      expq.push_back(x);
   endtask

   task automatic checkFrame(input string tag);
      int         n;
      logic [7:0] e;
      n = expq.size();
      for (int c = 0; c < 600; c++) begin
         if (rxq.size() >= n) break;
         @(negedge clk);
         #2;
      end
      checks++;
      assert (rxq.size() >= n) else begin
         errors++;
         $error("FAIL %s_timeout observed=%0d bytes expected=%0d bytes", tag, rxq.size(), n);
      end
      while (expq.size() > 0) begin
         e = expq.pop_front();
         if (rxq.size() > 0) checkOutput({tag, "_byte"}, 32'(rxq.pop_front()), 32'(e));
      end
   endtask

   task automatic waitIdle(input string tag);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      checkOutput(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [PW-1:0] p0;
      int            nTicks;
      int            vcBefore;
      checks            = 0;
      errors            = 0;
      validCycles       = 0;
      readyMode         = 0;
      modelCount        = 8'd0;
      stallPending      = 1'b0;
      stallData         = 8'd0;
      reset             = 1'b0;
      start             = 1'b0;
      stop              = 1'b0;
      continuous        = 1'b0;
      integration_ticks = 32'd0;
      tick              = 1'b0;
      pulses            = '0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_enable", 32'(corr_enable), 32'd0);
      checkOutput("rst_clear", 32'(corr_clear), 32'd0);
      checkOutput("rst_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_data", 32'(tx_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_count", 32'(frame_count), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);

      // Basic single frame, N=3, with latency and clear-width checks
      $display("[TB] basic frame");
      integration_ticks = 32'd3;
      pulses            = 16'h1234;
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("clear_high", 32'(corr_clear), 32'd1);
      checkOutput("enable_in_clear", 32'(corr_enable), 32'd1);
      @(negedge clk);
      checkOutput("clear_one_cycle", 32'(corr_clear), 32'd0);
      checkOutput("enable_integrate", 32'(corr_enable), 32'd1);
      pulseTick();
      @(negedge clk);
      checkOutput("enable_tick1", 32'(corr_enable), 32'd1);
      pulseTick();
      @(negedge clk);
      checkOutput("enable_tick2", 32'(corr_enable), 32'd1);
      pulseTick();
      @(negedge clk);
      checkOutput("enable_settle1", 32'(corr_enable), 32'd0);
      checkOutput("valid_lat1", 32'(tx_valid), 32'd0);
      @(negedge clk);
      checkOutput("enable_settle2", 32'(corr_enable), 32'd0);
      @(negedge clk);
      checkOutput("valid_lat3", 32'(tx_valid), 32'd0);
      @(negedge clk);
      checkOutput("valid_lat4", 32'(tx_valid), 32'd1);
      checkOutput("first_byte_sync", 32'(tx_data), 32'hA5);
      expectFrame(modelCount, 16'h1234);
      modelCount++;
      checkFrame("basic");
      checkOutput("basic_count", 32'(frame_count), 32'(modelCount));
      waitIdle("basic_idle");

      // Zero frame length behaves as a single tick
      $display("[TB] zero length");
      integration_ticks = 32'd0;
      pulses            = PW'($urandom);
      applyStimulus(1'b1, 1'b0);
      pulseTick();
      @(negedge clk);
      checkOutput("zero_n_settle", 32'(corr_enable), 32'd0);
      expectFrame(modelCount, pulses);
      modelCount++;
      checkFrame("zero_n");
      waitIdle("zero_n_idle");

      // Randomised frames with stalls; first one toggles ready on the reference payload
      $display("[TB] random frames");
      for (int i = 0; i < 4; i++) begin
         readyMode         = (i == 0) ? 1 : int'($urandom_range(0, 2));
         pulses            = (i == 0) ? 16'h1234 : PW'($urandom);
         nTicks            = int'($urandom_range(1, 4));
         integration_ticks = 32'(nTicks);
         applyStimulus(1'b1, 1'b0);
         for (int t = 0; t < nTicks; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            pulseTick();
         end
         expectFrame(modelCount, pulses);
         modelCount++;
         checkFrame("rand");
         checkOutput("rand_count", 32'(frame_count), 32'(modelCount));
         waitIdle("rand_idle");
      end
      readyMode = 0;

      // Continuous run against a stalled sink: second snapshot overruns
      $display("[TB] overrun");
      readyMode         = 3;
      continuous        = 1'b1;
      integration_ticks = 32'd1;
      p0                = PW'($urandom);
      pulses            = p0;
      repeat (2) @(posedge clk);
      applyStimulus(1'b1, 1'b0);
      pulseTick();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("ovr_first_clean", 32'(overrun), 32'd0);
      pulseTick();
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      checkOutput("ovr_flag", 32'(overrun), 32'd1);
      checkOutput("ovr_count", 32'(frame_count), 32'(modelCount + 8'd2));
      checkOutput("ovr_enable_off", 32'(corr_enable), 32'd0);
      checkOutput("ovr_stalled_sync", 32'(tx_data), 32'hA5);
      checkOutput("ovr_busy", 32'(busy), 32'd1);
      expectFrame(modelCount, p0);
      modelCount = modelCount + 8'd2;
      continuous = 1'b0;
      readyMode  = 0;
      checkFrame("ovr");
      repeat (20) @(negedge clk);
      checkOutput("ovr_single_frame", 32'(rxq.size()), 32'd0);
      checkOutput("ovr_sticky", 32'(overrun), 32'd1);

      // Start and stop together from idle: stop wins, overrun not cleared
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("startstop_busy", 32'(busy), 32'd0);
      checkOutput("startstop_clear", 32'(corr_clear), 32'd0);
      checkOutput("startstop_overrun", 32'(overrun), 32'd1);

      // Stop on the second integrate cycle
      $display("[TB] stop");
      integration_ticks = 32'd5;
      vcBefore          = validCycles;
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("start_clears_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("stop_pre_enable", 32'(corr_enable), 32'd1);
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      checkOutput("stop_enable", 32'(corr_enable), 32'd0);
      checkOutput("stop_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      checkOutput("stop_no_valid", 32'(validCycles), 32'(vcBefore));
      checkOutput("stop_count", 32'(frame_count), 32'(modelCount));

      // Asynchronous reset in the middle of a payload byte
      $display("[TB] reset mid-frame");
      rxq.delete();
      continuous        = 1'b1;
      integration_ticks = 32'd1;
      pulses            = PW'($urandom);
      applyStimulus(1'b1, 1'b0);
      pulseTick();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #2;
         if (rxq.size() >= 3) break;
      end
      checkOutput("mid_reached", 32'(rxq.size()), 32'd3);
      checkOutput("mid_pre_valid", 32'(tx_valid), 32'd1);
      checkOutput("mid_pre_enable", 32'(corr_enable), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid_valid_async", 32'(tx_valid), 32'd0);
      checkOutput("mid_enable_async", 32'(corr_enable), 32'd0);
      continuous = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      rxq.delete();
      expq.delete();
      modelCount = 8'd0;
      @(negedge clk);
      checkOutput("post_rst_count", 32'(frame_count), 32'd0);
      integration_ticks = 32'd2;
      pulses            = PW'($urandom);
      applyStimulus(1'b1, 1'b0);
      pulseTick();
      pulseTick();
      expectFrame(modelCount, pulses);
      modelCount++;
      checkFrame("post_rst");
      waitIdle("post_rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
